// File: rtl/if_stage_prefetch_pkg.sv
// Shared fetch-stage definitions: default widths, PC step and branch-target arithmetic.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package if_stage_prefetch_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          DATA_W_DEF   = 32;
  localparam int          DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam int          PC_STEP      = 4;

  // Branch target = pc + 4 + (immed << 2). Computed at 64 bits; callers truncate
  // to their own address width, which yields the required modulo-2^ADDR_W wrap.
  function automatic logic [63:0] branch_target(input logic [63:0] pc,
                                                input logic [63:0] immed);
    return pc + 64'(PC_STEP) + (immed << 2);
  endfunction

endpackage

// File: rtl/if_stage_prefetch_sync_fifo.sv
// Synchronous FIFO holding prefetched {instr, pc} entries; head is read combinationally.
// Latency: a push becomes visible at the head on the cycle after the write edge.
// Backpressure: push is dropped when full unless a pop frees a slot the same cycle; flush wins over push/pop.
// Ports: i_clk/i_rst clock and async reset; i_push/i_push_dat write; i_pop read-advance;
//        i_flush clears the queue; o_head head entry; o_count occupancy; o_empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (PW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: PC, 1-cycle imem fetch, DEPTH-entry prefetch queue, branch redirect.
// Latency: fetch issue to Instr_Valid is 2 cycles; redirect strobe to target valid is 3 cycles.
// Backpressure: decode holds Instr_Ready low; fetch stops once queue plus in-flight reaches DEPTH.
// Ports: Clk/Reset; PC_LdEn fetch enable; PC_sel/PC_Immed/Redir_PC redirect;
//        Imem_Req/Imem_Addr/Imem_Rdata memory side; Instr/Instr_PC/Instr_Valid/Instr_Ready decode side.
module if_stage_prefetch
  import if_stage_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PC_LdEn,
  input  logic              PC_sel,
  input  logic [ADDR_W-1:0] PC_Immed,
  input  logic [ADDR_W-1:0] Redir_PC,
  output logic              Imem_Req,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic [DATA_W-1:0] Imem_Rdata,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] Instr_PC,
  output logic              Instr_Valid,
  input  logic              Instr_Ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;

  logic [ADDR_W-1:0]        w_target;
  logic [CW-1:0]            w_count;
  logic                     w_empty;
  logic                     w_room;
  logic                     w_issue;
  logic                     w_pop;
  logic [DATA_W+ADDR_W-1:0] w_head;

  // Redirect target, truncated to ADDR_W and kept word aligned.
  assign w_target = ADDR_W'(branch_target(64'(Redir_PC), 64'(PC_Immed))) & ~ADDR_W'(3);

  // Room is judged before any same-cycle pop; DEPTH+1 still fits in CW bits.
  assign w_room  = (w_count + CW'(r_inflight)) < CW'(DEPTH);
  // Reset gates the request combinationally so it drops the instant Reset rises.
  assign w_issue = PC_LdEn && !PC_sel && w_room && !Reset;

  assign Imem_Req    = w_issue;
  assign Imem_Addr   = r_pc;
  assign Instr_Valid = !w_empty;
  assign w_pop       = Instr_Valid && Instr_Ready;
  assign Instr       = w_head[DATA_W+ADDR_W-1:ADDR_W];
  assign Instr_PC    = w_head[ADDR_W-1:0];

  // A redirect never issues, so clearing the in-flight flag plus the queue flush
  // (which overrides the response being written this cycle) kills all stale fetches.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (PC_sel) begin
      r_pc       <= w_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + ADDR_W'(PC_STEP);
        r_req_pc <= r_pc;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_push     (r_inflight),
    .i_push_dat ({Imem_Rdata, r_req_pc}),
    .i_pop      (w_pop),
    .i_flush    (PC_sel),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty)
  );

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model tracks the 2-cycle fetch and 3-cycle redirect behaviour.
// Backpressure: randomized Instr_Ready and PC_LdEn exercise full/empty and stall paths.
module tb_if_stage_prefetch;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PC_LdEn;
  logic        PC_sel;
  logic [31:0] PC_Immed;
  logic [31:0] Redir_PC;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Rdata;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_Valid;
  logic        Instr_Ready;

  if_stage_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PC_LdEn     (PC_LdEn),
    .PC_sel      (PC_sel),
    .PC_Immed    (PC_Immed),
    .Redir_PC    (Redir_PC),
    .Imem_Req    (Imem_Req),
    .Imem_Addr   (Imem_Addr),
    .Imem_Rdata  (Imem_Rdata),
    .Instr       (Instr),
    .Instr_PC    (Instr_PC),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a plain queue of {instr, pc}, the next fetch PC and one pending response.
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          env_req;
  logic [31:0] env_addr;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 32'h0;
    m_pend = 0;
  endtask

  function automatic bit model_req();
    return !Reset && PC_LdEn && !PC_sel && ((q.size() + int'(m_pend)) < DEPTH);
  endfunction

  // Compare every output against the model, on the falling edge.
  task automatic sample();
    bit er;
    @(negedge Clk);
    er = model_req();
    chk("req", 32'(Imem_Req), 32'(er));
    if (er) chk("addr", Imem_Addr, m_pc);
    chk("valid", 32'(Instr_Valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("instr", Instr, q[0].ins);
      chk("instr_pc", Instr_PC, q[0].pc);
    end
    env_req  = Imem_Req;
    env_addr = Imem_Addr;
  endtask

  // Advance the model across the rising edge, then answer the memory request.
  task automatic advance();
    bit er;
    er = model_req();
    @(posedge Clk);
    if (Reset) begin
      model_reset();
    end else begin
      if (q.size() != 0 && Instr_Ready) void'(q.pop_front());
      if (PC_sel) begin
        q.delete();
        m_pend = 0;
        m_pc   = (Redir_PC + 32'd4 + (PC_Immed << 2)) & ~32'd3;
      end else begin
        if (m_pend) q.push_back('{ins: rom(m_pend_pc), pc: m_pend_pc});
        m_pend = er;
        if (er) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
    end
    #1;
    Imem_Rdata = env_req ? rom(env_addr) : $urandom();
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   nreq;
    logic [31:0] first_addr;
    bit   seen;

    Reset = 1'b1; PC_LdEn = 1'b1; PC_sel = 1'b0; PC_Immed = '0; Redir_PC = '0;
    Instr_Ready = 1'b1; Imem_Rdata = '0;
    model_reset();
    #2;
    chk("rst_valid", 32'(Instr_Valid), 32'd0);
    chk("rst_req", 32'(Imem_Req), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_instr_pc", Instr_PC, 32'd0);
    advance();
    tick();
    Reset = 1'b0;

    // 1: streaming from reset, one instruction per cycle.
    sample(); chk("t1_addr0", Imem_Addr, 32'h0); chk("t1_req0", 32'(Imem_Req), 32'd1); advance();
    sample(); chk("t1_addr1", Imem_Addr, 32'h4); chk("t1_valid1", 32'(Instr_Valid), 32'd0); advance();
    sample(); chk("t1_valid2", 32'(Instr_Valid), 32'd1); chk("t1_pc2", Instr_PC, 32'h0);
              chk("t1_ins2", Instr, 32'd0); advance();
    sample(); chk("t1_pc3", Instr_PC, 32'h4); chk("t1_ins3", Instr, 32'd1); advance();
    sample(); chk("t1_pc4", Instr_PC, 32'h8); chk("t1_ins4", Instr, 32'd2); advance();

    // 3: redirect with a fetch in flight.
    PC_sel = 1'b1; Redir_PC = 32'h20; PC_Immed = 32'd2;
    tick();
    PC_sel = 1'b0;
    sample(); chk("t3_addr", Imem_Addr, 32'h2C); chk("t3_valid1", 32'(Instr_Valid), 32'd0); advance();
    sample(); chk("t3_valid2", 32'(Instr_Valid), 32'd0); advance();
    sample(); chk("t3_valid3", 32'(Instr_Valid), 32'd1); chk("t3_pc", Instr_PC, 32'h2C); advance();

    // 4: negative offset and wrap-around targets.
    PC_sel = 1'b1; Redir_PC = 32'h40; PC_Immed = 32'hFFFF_FFFB;
    tick();
    PC_sel = 1'b0;
    sample(); chk("t4_neg", Imem_Addr, 32'h30); advance();
    PC_sel = 1'b1; Redir_PC = 32'hFFFF_FFFC; PC_Immed = 32'h0;
    tick();
    PC_sel = 1'b0;
    sample(); chk("t4_wrap", Imem_Addr, 32'h0); advance();

    // 5: fetch disabled, queue drains, then resumes at held PC.
    PC_LdEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample(); chk("t5_noreq", 32'(Imem_Req), 32'd0); advance();
    end
    sample(); chk("t5_empty", 32'(Instr_Valid), 32'd0); advance();
    PC_LdEn = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // 2: back-pressure fills the queue from reset, then drains in order.
    do_reset();
    Instr_Ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      sample(); nreq += int'(Imem_Req); advance();
    end
    sample();
    chk("t2_reqs", 32'(nreq), 32'd4);
    chk("t2_full_req", 32'(Imem_Req), 32'd0);
    chk("t2_head_pc", Instr_PC, 32'h0);
    advance();
    Instr_Ready = 1'b1;
    seen = 0; first_addr = 32'hDEAD;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (Imem_Req && !seen) begin seen = 1; first_addr = Imem_Addr; end
      advance();
    end
    chk("t2_resume", first_addr, 32'h10);

    // 6: asynchronous reset mid-burst with a partially full queue.
    Instr_Ready = 1'b0;
    tick(); tick();
    #2 Reset = 1'b1;
    #1;
    chk("t6_valid", 32'(Instr_Valid), 32'd0);
    chk("t6_req", 32'(Imem_Req), 32'd0);
    model_reset();
    advance();
    tick();
    Reset = 1'b0;
    Instr_Ready = 1'b1;
    sample(); chk("t6_addr", Imem_Addr, 32'h0); chk("t6_req1", 32'(Imem_Req), 32'd1); advance();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      PC_LdEn     = ($urandom_range(0, 99) < 85);
      Instr_Ready = ($urandom_range(0, 99) < 65);
      PC_sel      = ($urandom_range(0, 99) < 7);
      Redir_PC    = {$urandom_range(0, 255), 2'b00};
      PC_Immed    = 32'($signed($urandom_range(0, 64)) - 32);
      tick();
    end
    PC_sel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
